// File: rtl/afp_pkg.sv
// rtl/afp_pkg.sv - shared types and constants for the AFP dot-product accumulator
package afp_pkg;

  localparam int AFP_W     = 4;
  localparam int PM_W      = 4;
  localparam int PO_W      = 3;
  localparam int ALIGN_W   = 10;
  localparam int FRAC_BITS = 8;
  localparam int MAX_PO    = 6;

  typedef struct packed {
    logic            sign;
    logic [PM_W-1:0] pm;
    logic [PO_W-1:0] po;
  } afp_prod_t;

  typedef enum logic {
    ACCUM,
    HOLD
  } acc_state_t;

endpackage

// File: rtl/afp_prod_align.sv
// rtl/afp_prod_align.sv - aligns one unnormalized AFP product to a signed fixed-point addend
module afp_prod_align
  import afp_pkg::*;
#(
  parameter int ACC_W = 18
) (
  input  afp_prod_t        prod,
  output logic [ACC_W:0]   addend
);

  logic [ALIGN_W-1:0] mag;

  // Shift pm so that pm/4 * 2^-po lands on an LSB of 2^-FRAC_BITS, then apply the sign.
  // Offsets beyond MAX_PO are not legal products and contribute nothing.
  always_comb begin
    mag    = '0;
    addend = '0;
    if (prod.po <= PO_W'(MAX_PO)) begin
      mag    = ALIGN_W'(prod.pm) << (PO_W'(MAX_PO) - prod.po);
      addend = prod.sign ? -((ACC_W+1)'(mag)) : (ACC_W+1)'(mag);
    end
  end

endmodule

// File: rtl/afp_dot_accumulator.sv
// rtl/afp_dot_accumulator.sv - accumulates an AFP product stream into a signed dot product (AFP_ACC_SAT_EN selects saturation)
module afp_dot_accumulator
  import afp_pkg::*;
#(
  parameter  int ACC_W   = 18,
  parameter  int MAX_LEN = 64,
  localparam int CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sign,
  input  logic [PM_W-1:0]         in_pm,
  input  logic [PO_W-1:0]         in_po,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0]        out_count,
  output logic                    out_trunc,
  output logic                    out_ovf
);

  acc_state_t       state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] count;
  logic             ovf;

  afp_prod_t        prod;
  logic [ACC_W:0]   addend;
  logic [ACC_W:0]   sum_ext;
  logic [ACC_W-1:0] acc_next;
  logic             ovf_now;
  logic [CNT_W-1:0] count_inc;
  logic             len_hit;
  logic             beat;

  assign prod      = '{sign: in_sign, pm: in_pm, po: in_po};
  assign beat      = in_valid && in_ready;
  assign count_inc = count + 1'b1;
  assign len_hit   = (count_inc == CNT_W'(MAX_LEN));

  afp_prod_align #(
    .ACC_W (ACC_W)
  ) u_align (
    .prod   (prod),
    .addend (addend)
  );

  // One extra bit of headroom exposes overflow as a mismatch of the top two sum bits.
  always_comb begin
    sum_ext = {acc[ACC_W-1], acc} + addend;
    ovf_now = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
`ifdef AFP_ACC_SAT_EN
    if (ovf_now) begin
      acc_next = sum_ext[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      acc_next = sum_ext[ACC_W-1:0];
    end
`else
    acc_next = sum_ext[ACC_W-1:0];
`endif
  end

  // Accumulate beats in ACCUM, present the latched result in HOLD until it is taken.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ACCUM;
      acc       <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_trunc <= 1'b0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          in_ready <= 1'b1;
          if (beat) begin
            acc   <= acc_next;
            count <= count_inc;
            ovf   <= ovf | ovf_now;
            if (in_last || len_hit) begin
              state     <= HOLD;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_sum   <= acc_next;
              out_count <= count_inc;
              out_trunc <= len_hit && !in_last;
              out_ovf   <= ovf | ovf_now;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= ACCUM;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            acc       <= '0;
            count     <= '0;
            ovf       <= 1'b0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

  // Offsets above MAX_PO never come from a legal multiplier.
  assert property (@(posedge clk) disable iff (!reset_n) beat |-> (in_po <= PO_W'(MAX_PO)));

endmodule

// File: tb/tb_afp_dot_accumulator.sv
// tb/tb_afp_dot_accumulator.sv - directed self-checking bench for afp_dot_accumulator
module tb_afp_dot_accumulator;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic       in_sign;
  logic [3:0] in_pm;
  logic [2:0] in_po;
  logic       in_last;
  logic       out_ready;

  logic               m_in_ready, m_out_valid, m_out_trunc, m_out_ovf;
  logic signed [17:0] m_out_sum;
  logic [6:0]         m_out_count;

  logic               l_in_ready, l_out_valid, l_out_trunc, l_out_ovf;
  logic signed [17:0] l_out_sum;
  logic [2:0]         l_out_count;

  logic               n_in_ready, n_out_valid, n_out_trunc, n_out_ovf;
  logic signed [10:0] n_out_sum;
  logic [6:0]         n_out_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  afp_dot_accumulator #(.ACC_W(18), .MAX_LEN(64)) u_main (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(m_in_ready),
    .in_sign(in_sign), .in_pm(in_pm), .in_po(in_po), .in_last(in_last),
    .out_valid(m_out_valid), .out_ready(out_ready), .out_sum(m_out_sum),
    .out_count(m_out_count), .out_trunc(m_out_trunc), .out_ovf(m_out_ovf)
  );

  afp_dot_accumulator #(.ACC_W(18), .MAX_LEN(4)) u_len (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(l_in_ready),
    .in_sign(in_sign), .in_pm(in_pm), .in_po(in_po), .in_last(in_last),
    .out_valid(l_out_valid), .out_ready(out_ready), .out_sum(l_out_sum),
    .out_count(l_out_count), .out_trunc(l_out_trunc), .out_ovf(l_out_ovf)
  );

  afp_dot_accumulator #(.ACC_W(11), .MAX_LEN(64)) u_nar (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(n_in_ready),
    .in_sign(in_sign), .in_pm(in_pm), .in_po(in_po), .in_last(in_last),
    .out_valid(n_out_valid), .out_ready(out_ready), .out_sum(n_out_sum),
    .out_count(n_out_count), .out_trunc(n_out_trunc), .out_ovf(n_out_ovf)
  );

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic rdy(input int sel);
    case (sel)
      0:       return m_in_ready;
      1:       return l_in_ready;
      default: return n_in_ready;
    endcase
  endfunction

  function automatic logic vld(input int sel);
    case (sel)
      0:       return m_out_valid;
      1:       return l_out_valid;
      default: return n_out_valid;
    endcase
  endfunction

  // Called at a falling edge; returns at the falling edge after the beat is accepted.
  task automatic send_beat(input int sel, input logic s, input logic [3:0] pm,
                           input logic [2:0] po, input logic last);
    int n = 0;
    in_valid = 1'b1;
    in_sign  = s;
    in_pm    = pm;
    in_po    = po;
    in_last  = last;
    while (!rdy(sel) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("beat_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic take_result(input int sel);
    int n = 0;
    out_ready = 1'b1;
    while (!vld(sel) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("take_timeout", 0, 1);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    reset_n   = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_pm     = '0;
    in_po     = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_in_ready", m_in_ready, 0);
    check("rst_out_valid", m_out_valid, 0);
    check("rst_out_sum", m_out_sum, 0);
    check("rst_out_count", m_out_count, 0);
    check("rst_out_trunc", m_out_trunc, 0);
    check("rst_out_ovf", m_out_ovf, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", m_in_ready, 1);

    // single beat: 4/4 * 2^0 = 1.0 -> 256
    send_beat(0, 0, 4, 0, 1);
    check("t1_valid", m_out_valid, 1);
    check("t1_sum", m_out_sum, 256);
    check("t1_count", m_out_count, 1);
    check("t1_trunc", m_out_trunc, 0);
    check("t1_ovf", m_out_ovf, 0);
    check("t1_in_ready", m_in_ready, 0);
    take_result(0);
    check("t1_valid_clr", m_out_valid, 0);
    check("t1_ready_back", m_in_ready, 1);

    // 576 - 128 + 6 = 454
    send_beat(0, 0, 9, 0, 0);
    send_beat(0, 1, 4, 1, 0);
    send_beat(0, 0, 6, 6, 1);
    check("t2_valid", m_out_valid, 1);
    check("t2_sum", m_out_sum, 454);
    check("t2_count", m_out_count, 3);
    check("t2_trunc", m_out_trunc, 0);

    // back-pressure: result held stable, no input accepted
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_hold_valid", m_out_valid, 1);
      check("t3_hold_sum", m_out_sum, 454);
      check("t3_hold_count", m_out_count, 3);
      check("t3_hold_in_ready", m_in_ready, 0);
    end
    take_result(0);
    send_beat(0, 0, 4, 2, 1);
    check("t3_next_sum", m_out_sum, 64);
    check("t3_next_count", m_out_count, 1);
    take_result(0);

    // MAX_LEN=4 forced termination
    do_reset();
    for (int i = 0; i < 4; i++) send_beat(1, 0, 4, 0, 0);
    check("t4_valid", l_out_valid, 1);
    check("t4_sum", l_out_sum, 1024);
    check("t4_count", l_out_count, 4);
    check("t4_trunc", l_out_trunc, 1);
    check("t4_ovf", l_out_ovf, 0);
    in_valid = 1'b1;
    in_sign  = 1'b0;
    in_pm    = 4'd4;
    in_po    = 3'd0;
    in_last  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_blocked_ready", l_in_ready, 0);
      check("t4_blocked_count", l_out_count, 4);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("t4_hs_valid", l_out_valid, 0);
    check("t4_hs_ready", l_in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("t4_next_sum", l_out_sum, 256);
    check("t4_next_count", l_out_count, 1);
    check("t4_next_trunc", l_out_trunc, 0);

    // ACC_W=11 overflow: 576 + 576 = 1152 exceeds 1023
    do_reset();
    send_beat(2, 0, 9, 0, 0);
    send_beat(2, 0, 9, 0, 1);
    check("t5_valid", n_out_valid, 1);
`ifdef AFP_ACC_SAT_EN
    check("t5_sum_sat", n_out_sum, 1023);
`else
    check("t5_sum_wrap", n_out_sum, -896);
`endif
    check("t5_ovf", n_out_ovf, 1);
    check("t5_count", n_out_count, 2);

    // reset mid-vector discards the partial sum
    do_reset();
    send_beat(0, 0, 9, 0, 0);
    send_beat(0, 0, 9, 0, 0);
    reset_n = 1'b0;
    @(negedge clk);
    check("t6_rst_valid", m_out_valid, 0);
    check("t6_rst_sum", m_out_sum, 0);
    check("t6_rst_count", m_out_count, 0);
    check("t6_rst_in_ready", m_in_ready, 0);
    reset_n = 1'b1;
    send_beat(0, 1, 4, 0, 1);
    check("t6_valid", m_out_valid, 1);
    check("t6_sum", m_out_sum, -256);
    check("t6_count", m_out_count, 1);
    check("t6_ovf", m_out_ovf, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
